// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder and its result sink.
package adder_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic              c;
        logic [DATA_W-1:0] sum;
    } result_t;

endpackage

// File: rtl/result_fifo_mem.sv
// Result storage: register array with one write port and an asynchronous read port.
module result_fifo_mem #(
    parameter int ENTRY_W = adder_pkg::DATA_W + 1,
    parameter int DEPTH   = 4,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the top's count.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/adder_result_sink.sv
// Accepts adder results into a small FWFT FIFO and re-presents them with valid/ready.
module adder_result_sink
    import adder_pkg::*;
#(
    parameter int DATA_W  = adder_pkg::DATA_W,
    parameter int DEPTH   = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validin,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              cy_in,
    output logic              out_allow,
    input  logic              flush,
    input  logic              rd_ready,
    output logic              validout,
    output logic [DATA_W-1:0] sum_out,
    output logic              c_out,
    output logic [CNT_W-1:0]  count,
    output logic [31:0]       acc_cnt
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       acc_q, acc_d;
    logic              wr_en, rd_en;
    logic [DATA_W:0]   rd_data;

    // Handshakes depend only on the registered count, so no input-to-output path exists.
    assign out_allow = (count_q != CNT_W'(DEPTH));
    assign validout  = (count_q != '0);

    assign wr_en = validin  && out_allow && !flush;
    assign rd_en = rd_ready && validout  && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                acc_d    = acc_q + 32'd1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_en && !wr_en) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end

    result_fifo_mem #(
        .ENTRY_W (DATA_W + 1),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({cy_in, sum_in}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Head is masked to zero when empty so stale storage never leaks out.
    assign sum_out = validout ? rd_data[DATA_W-1:0] : '0;
    assign c_out   = validout ? rd_data[DATA_W]     : 1'b0;
    assign count   = count_q;
    assign acc_cnt = acc_q;

endmodule
